// File: rtl/alu_if.sv
// ALU issue/result bundle: operands and opcode in, registered result and flags out.
// master drives operands and samples results; slave is the ALU side.
interface alu_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        alu_con;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              zero;

  modport master (
    output in_valid, a, b, alu_con,
    input  out, out_valid, zero
  );

  modport slave (
    input  in_valid, a, b, alu_con,
    output out, out_valid, zero
  );
endinterface

// File: rtl/alu.sv
// Registered RV32 integer ALU; ALU_MINMAX_EN builds the signed/unsigned min/max ops (11-14).
// Latency: 1 cycle, full throughput.
// Backpressure: none; an issued operation always completes, idle cycles hold out/zero.
module alu #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_SLL    = 4'd2,
    OP_SLT    = 4'd3,
    OP_SLTU   = 4'd4,
    OP_XOR    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_OR     = 4'd8,
    OP_AND    = 4'd9,
    OP_PASS_B = 4'd10,
    OP_MIN    = 4'd11,
    OP_MAX    = 4'd12,
    OP_MINU   = 4'd13,
    OP_MAXU   = 4'd14,
    OP_PASS_A = 4'd15
  } alu_op_e;

  logic [SH_W-1:0]   sh;
  logic              lt_s;
  logic              lt_u;
  logic [DATA_W-1:0] res;

  // Only the low shift bits matter, so a shift by DATA_W wraps to a shift by 0.
  assign sh   = bus.b[SH_W-1:0];
  assign lt_s = $signed(bus.a) < $signed(bus.b);
  assign lt_u = bus.a < bus.b;

  always_comb begin
    res = '0;
    case (alu_op_e'(bus.alu_con))
      OP_ADD:    res = bus.a + bus.b;
      OP_SUB:    res = bus.a - bus.b;
      OP_SLL:    res = bus.a << sh;
      OP_SLT:    res = {{(DATA_W-1){1'b0}}, lt_s};
      OP_SLTU:   res = {{(DATA_W-1){1'b0}}, lt_u};
      OP_XOR:    res = bus.a ^ bus.b;
      OP_SRL:    res = bus.a >> sh;
      OP_SRA:    res = $unsigned($signed(bus.a) >>> sh);
      OP_OR:     res = bus.a | bus.b;
      OP_AND:    res = bus.a & bus.b;
      OP_PASS_B: res = bus.b;
`ifdef ALU_MINMAX_EN
      OP_MIN:    res = lt_s ? bus.a : bus.b;
      OP_MAX:    res = lt_s ? bus.b : bus.a;
      OP_MINU:   res = lt_u ? bus.a : bus.b;
      OP_MAXU:   res = lt_u ? bus.b : bus.a;
`else
      // Min/max not built: these opcodes return zero (and so flag zero).
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU: res = '0;
`endif
      OP_PASS_A: res = bus.a;
      default:   res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.zero      <= 1'b0;
    end else if (bus.in_valid) begin
      bus.out       <= res;
      bus.out_valid <= 1'b1;
      bus.zero      <= (res == '0);
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed-vector scoreboard bench for alu; expected results are hand-computed constants.
module tb_alu;
  localparam int DATA_W = 32;
`ifdef ALU_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  typedef struct {
    logic [31:0] val;
    logic        z;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  alu_if #(.DATA_W(DATA_W)) bus ();

  alu #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // Monitor: whenever the DUT presents a result, pop and compare.
  always @(posedge clk) begin
    #1;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=0x%08h required=no_result", bus.out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_out"}, bus.out, e.val);
        chk({e.name, "_zero"}, {31'd0, bus.zero}, {31'd0, e.z});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input string nm);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_con  = op;
    bus.a        = av;
    bus.b        = bv;
    e.val  = ev;
    e.z    = (ev == 32'd0);
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.alu_con  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset after a result is held
    issue(4'd0, 32'd1, 32'd2, 32'd3, "pre_rst_add");
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", bus.out, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 32'd10, 32'd16, 32'd26, "post_rst_add");

    // a=10, b=16 sweep
    issue(4'd1,  32'd10, 32'd16, 32'hFFFFFFFA, "sub");
    issue(4'd2,  32'd10, 32'd16, 32'h000A0000, "sll");
    issue(4'd3,  32'd10, 32'd16, 32'd1,        "slt");
    issue(4'd4,  32'd10, 32'd16, 32'd1,        "sltu");
    issue(4'd5,  32'd10, 32'd16, 32'h1A,       "xor");
    issue(4'd6,  32'd10, 32'd16, 32'd0,        "srl");
    issue(4'd7,  32'd10, 32'd16, 32'd0,        "sra");
    issue(4'd8,  32'd10, 32'd16, 32'h1A,       "or");
    issue(4'd9,  32'd10, 32'd16, 32'd0,        "and");
    issue(4'd10, 32'd10, 32'd16, 32'd16,       "pass_b");

    // a=-10, b=4
    issue(4'd3,  32'hFFFFFFF6, 32'd4, 32'd1,        "neg_slt");
    issue(4'd4,  32'hFFFFFFF6, 32'd4, 32'd0,        "neg_sltu");
    issue(4'd7,  32'hFFFFFFF6, 32'd4, 32'hFFFFFFFF, "neg_sra");
    issue(4'd6,  32'hFFFFFFF6, 32'd4, 32'h0FFFFFFF, "neg_srl");
    issue(4'd2,  32'hFFFFFFF6, 32'd4, 32'hFFFFFF60, "neg_sll");
    issue(4'd11, 32'hFFFFFFF6, 32'd4, MM ? 32'hFFFFFFF6 : 32'd0, "neg_min");
    issue(4'd12, 32'hFFFFFFF6, 32'd4, MM ? 32'd4        : 32'd0, "neg_max");
    issue(4'd13, 32'hFFFFFFF6, 32'd4, MM ? 32'd4        : 32'd0, "neg_minu");
    issue(4'd14, 32'hFFFFFFF6, 32'd4, MM ? 32'hFFFFFFF6 : 32'd0, "neg_maxu");
    issue(4'd15, 32'hFFFFFFF6, 32'd4, 32'hFFFFFFF6, "neg_pass_a");

    // Swapped operands a=4, b=-10
    issue(4'd14, 32'd4, 32'hFFFFFFF6, MM ? 32'hFFFFFFF6 : 32'd0, "sw_maxu");
    issue(4'd13, 32'd4, 32'hFFFFFFF6, MM ? 32'd4        : 32'd0, "sw_minu");
    issue(4'd3,  32'd4, 32'hFFFFFFF6, 32'd0,        "sw_slt");
    issue(4'd4,  32'd4, 32'hFFFFFFF6, 32'd1,        "sw_sltu");
    issue(4'd15, 32'd4, 32'hFFFFFFF6, 32'd4,        "sw_pass_a");
    issue(4'd2,  32'd4, 32'hFFFFFFF6, 32'h01000000, "sw_sll22");

    // Boundaries: shift of 32 acts as 0, ADD wrap, equal-operand MIN
    issue(4'd2,  32'd5,        32'd32, 32'd5, "sll_by_32");
    issue(4'd0,  32'hFFFFFFFF, 32'd1,  32'd0, "add_wrap");
    issue(4'd11, 32'd7,        32'd7,  MM ? 32'd7 : 32'd0, "min_equal");

    // Hold: idle cycles with changing operands leave out untouched
    issue(4'd0, 32'd1, 32'd2, 32'd3, "hold_add");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.alu_con  = 4'(i);
      @(posedge clk);
      #1;
      chk("hold_out", bus.out, 32'd3);
      chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // Back-to-back zero results
    issue(4'd1, 32'd5, 32'd5, 32'd0, "b2b_sub");
    issue(4'd8, 32'd0, 32'd0, 32'd0, "b2b_or");
    idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
